// File: rtl/fft_reorder32_if.sv
// Sample stream bundle around the reorder buffer: bit-reversed input side and natural-order output side.
// The slave modport is the buffer itself; the master modport is whatever drives it and consumes its output.
interface fft_reorder32_if #(
  parameter int DATA_W = 19
);
  logic                     valid_i;
  logic signed [DATA_W-1:0] data_in_r;
  logic signed [DATA_W-1:0] data_in_i;
  logic                     valid_o;
  logic                     sop_o;
  logic signed [DATA_W-1:0] data_out_r;
  logic signed [DATA_W-1:0] data_out_i;

  modport master (
    output valid_i, data_in_r, data_in_i,
    input  valid_o, sop_o, data_out_r, data_out_i
  );

  modport slave (
    input  valid_i, data_in_r, data_in_i,
    output valid_o, sop_o, data_out_r, data_out_i
  );
endinterface

// File: rtl/fft_reorder32.sv
// Ping-pong bit-reversal reorder buffer for the 32-point SDF FFT: X[0] appears 2 cycles after a frame's last input.
// No backpressure; a bank refills no faster than it drains, so frames stream out back-to-back without bubbles.
module fft_reorder32 #(
  parameter int DATA_W = 19,
  parameter int LOG2N  = 5
) (
  input  logic           clk,
  input  logic           rst,
  fft_reorder32_if.slave bus
);
  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  typedef enum logic {IDLE, READ} state_t;

  logic [2*DATA_W-1:0] mem [2*N];

  logic [LOG2N-1:0]    wr_cnt;
  logic [LOG2N-1:0]    wr_addr;
  logic                wr_bank;
  logic [LOG2N-1:0]    rd_cnt;
  logic                rd_bank;
  logic [1:0]          full;
  state_t              state;

  logic                wr_last;
  logic                rd_last;
  logic [1:0]          full_set;
  logic [1:0]          full_clr;
  logic [2*DATA_W-1:0] rd_word;

  // Writing at the bit-reversed address lets the reader sweep addresses linearly.
  always_comb begin
    wr_addr = '0;
    for (int b = 0; b < LOG2N; b++) begin
      wr_addr[b] = wr_cnt[LOG2N-1-b];
    end
  end

  assign wr_last  = bus.valid_i && (wr_cnt == LAST);
  assign rd_last  = (state == READ) && (rd_cnt == LAST);
  assign full_set = wr_last ? (2'b01 << wr_bank) : 2'b00;
  assign full_clr = rd_last ? (2'b01 << rd_bank) : 2'b00;
  assign rd_word  = mem[{rd_bank, rd_cnt}];

  always_ff @(posedge clk) begin
    if (bus.valid_i) begin
      mem[{wr_bank, wr_addr}] <= {bus.data_in_r, bus.data_in_i};
    end
  end

  // Set and clear can target different banks in the same cycle; both take effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      full <= (full & ~full_clr) | full_set;
      if (bus.valid_i) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_last) begin
          wr_bank <= ~wr_bank;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      rd_cnt         <= '0;
      rd_bank        <= 1'b0;
      bus.valid_o    <= 1'b0;
      bus.sop_o      <= 1'b0;
      bus.data_out_r <= '0;
      bus.data_out_i <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.valid_o    <= 1'b0;
          bus.sop_o      <= 1'b0;
          bus.data_out_r <= '0;
          bus.data_out_i <= '0;
          rd_cnt         <= '0;
          if (full[rd_bank]) begin
            state <= READ;
          end
        end
        READ: begin
          bus.valid_o    <= 1'b1;
          bus.sop_o      <= (rd_cnt == '0);
          bus.data_out_r <= rd_word[2*DATA_W-1 -: DATA_W];
          bus.data_out_i <= rd_word[DATA_W-1:0];
          if (rd_last) begin
            rd_cnt  <= '0;
            rd_bank <= ~rd_bank;
            // Continue straight into the other bank when it is already complete.
            if (!full[~rd_bank]) begin
              state <= IDLE;
            end
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_reorder32.sv
// Randomized bench for fft_reorder32: frames go in bit-reversed order, outputs are compared with a natural-order model.
module tb_fft_reorder32;
  localparam int DW = 19;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_reorder32_if #(.DATA_W(DW)) bus();

  fft_reorder32 #(.DATA_W(DW), .LOG2N(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic signed [DW-1:0] fr_r [4][32];
  logic signed [DW-1:0] fr_i [4][32];

  logic signed [DW-1:0] mon_r[$];
  logic signed [DW-1:0] mon_i[$];
  bit                   mon_sop[$];
  int                   mon_cyc[$];

  always @(negedge clk) begin
    if (bus.valid_o === 1'b1) begin
      mon_r.push_back(bus.data_out_r);
      mon_i.push_back(bus.data_out_i);
      mon_sop.push_back(bus.sop_o);
      mon_cyc.push_back(cyc);
    end
  end

  function automatic int bitrev5(input int x);
    return int'({x[0], x[1], x[2], x[3], x[4]});
  endfunction

  // Natural-order sample j of a frame is the input sample at index bitrev(j).
  function automatic logic signed [DW-1:0] exp_r(input int f, input int j);
    return fr_r[f][bitrev5(j)];
  endfunction

  function automatic logic signed [DW-1:0] exp_i(input int f, input int j);
    return fr_i[f][bitrev5(j)];
  endfunction

  task automatic clear_mon();
    mon_r.delete();
    mon_i.delete();
    mon_sop.delete();
    mon_cyc.delete();
  endtask

  task automatic fill_random(input int f);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r = $urandom;
      fr_r[f][i] = r[DW-1:0];
      r = $urandom;
      fr_i[f][i] = r[DW-1:0];
    end
  endtask

  task automatic drive_frames(input int nf, input bit gapped, output int last_edge);
    last_edge = 0;
    for (int f = 0; f < nf; f++) begin
      for (int i = 0; i < 32; i++) begin
        @(negedge clk);
        bus.valid_i   = 1'b1;
        bus.data_in_r = fr_r[f][i];
        bus.data_in_i = fr_i[f][i];
        last_edge     = cyc + 1;
        if (gapped) begin
          @(negedge clk);
          bus.valid_i   = 1'b0;
          bus.data_in_r = DW'($urandom);
        end
      end
    end
    @(negedge clk);
    bus.valid_i = 1'b0;
  endtask

  task automatic wait_outputs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      #1;
      ok = (mon_r.size() >= n);
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.valid_i   = 1'b0;
    bus.data_in_r = '0;
    bus.data_in_i = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.valid_o !== 1'b0 || bus.sop_o !== 1'b0)
      begin errors++; $display("FAIL reset_flags: valid_o=%b sop_o=%b, required 0 0", bus.valid_o, bus.sop_o); end
    checks++;
    if (bus.data_out_r !== '0 || bus.data_out_i !== '0)
      begin errors++; $display("FAIL reset_data: r=%0d i=%0d, required 0 0", bus.data_out_r, bus.data_out_i); end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    clear_mon();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      checks++;
      if (bus.valid_o !== 1'b0 || bus.sop_o !== 1'b0 || bus.data_out_r !== '0 || bus.data_out_i !== '0) begin
        errors++;
        $display("FAIL idle cycle %0d: valid=%b sop=%b r=%0d i=%0d, required all 0",
                 c, bus.valid_o, bus.sop_o, bus.data_out_r, bus.data_out_i);
      end
    end
  endtask

  task automatic test_single_frame();
    int last;
    bit ok;
    clear_mon();
    for (int i = 0; i < 32; i++) begin
      fr_r[0][i] = DW'(i);
      fr_i[0][i] = DW'(-i);
    end
    drive_frames(1, 1'b0, last);
    wait_outputs(32, 80, ok);
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (mon_r.size() != 32) begin
      errors++; $display("FAIL single_count: got %0d outputs, required 32", mon_r.size());
    end else begin
      for (int j = 0; j < 32; j++) begin
        checks++;
        if (mon_r[j] !== DW'(bitrev5(j)) || mon_i[j] !== DW'(-bitrev5(j)) ||
            mon_sop[j] !== (j == 0) || mon_cyc[j] != last + 2 + j) begin
          errors++;
          $display("FAIL single X[%0d]: r=%0d i=%0d sop=%b cyc=%0d, required r=%0d i=%0d sop=%b cyc=%0d",
                   j, mon_r[j], mon_i[j], mon_sop[j], mon_cyc[j], bitrev5(j), -bitrev5(j), j == 0, last + 2 + j);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int last, first;
    bit ok;
    clear_mon();
    for (int f = 0; f < 4; f++) fill_random(f);
    drive_frames(4, 1'b0, last);
    first = last - 96 + 2;
    wait_outputs(128, 200, ok);
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (mon_r.size() != 128) begin
      errors++; $display("FAIL b2b_count: got %0d outputs, required 128", mon_r.size());
    end else begin
      for (int j = 0; j < 128; j++) begin
        checks++;
        if (mon_r[j] !== exp_r(j / 32, j % 32) || mon_i[j] !== exp_i(j / 32, j % 32) ||
            mon_sop[j] !== (j % 32 == 0) || mon_cyc[j] != first + j) begin
          errors++;
          $display("FAIL b2b out %0d: r=%0d i=%0d sop=%b cyc=%0d, required r=%0d i=%0d sop=%b cyc=%0d",
                   j, mon_r[j], mon_i[j], mon_sop[j], mon_cyc[j],
                   exp_r(j / 32, j % 32), exp_i(j / 32, j % 32), j % 32 == 0, first + j);
        end
      end
    end
  endtask

  task automatic test_gapped();
    int last;
    bit ok;
    clear_mon();
    fill_random(0);
    drive_frames(1, 1'b1, last);
    wait_outputs(32, 80, ok);
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (mon_r.size() != 32) begin
      errors++; $display("FAIL gapped_count: got %0d outputs, required 32", mon_r.size());
    end else begin
      for (int j = 0; j < 32; j++) begin
        checks++;
        if (mon_r[j] !== exp_r(0, j) || mon_i[j] !== exp_i(0, j) ||
            mon_sop[j] !== (j == 0) || mon_cyc[j] != last + 2 + j) begin
          errors++;
          $display("FAIL gapped X[%0d]: r=%0d i=%0d sop=%b cyc=%0d, required r=%0d i=%0d sop=%b cyc=%0d",
                   j, mon_r[j], mon_i[j], mon_sop[j], mon_cyc[j], exp_r(0, j), exp_i(0, j), j == 0, last + 2 + j);
        end
      end
    end
  endtask

  task automatic test_extremes();
    int last;
    bit ok;
    clear_mon();
    fill_random(0);
    fr_r[0][0]  = 19'sh40000;
    fr_i[0][0]  = 19'sh3FFFF;
    fr_r[0][31] = 19'sh3FFFF;
    fr_i[0][31] = 19'sh40000;
    drive_frames(1, 1'b0, last);
    wait_outputs(32, 80, ok);
    #1;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL extremes_timeout: got %0d outputs, required 32", mon_r.size());
    end else begin
      checks++;
      if (mon_r[0] !== 19'sh40000 || mon_i[0] !== 19'sh3FFFF || mon_sop[0] !== 1'b1)
        begin errors++; $display("FAIL extremes X[0]: r=%0d i=%0d sop=%b, required -262144 262143 1", mon_r[0], mon_i[0], mon_sop[0]); end
      checks++;
      if (mon_r[31] !== 19'sh3FFFF || mon_i[31] !== 19'sh40000)
        begin errors++; $display("FAIL extremes X[31]: r=%0d i=%0d, required 262143 -262144", mon_r[31], mon_i[31]); end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int last;
    bit ok;
    clear_mon();
    fill_random(0);
    fill_random(1);
    drive_frames(1, 1'b0, last);
    // Partial second frame while the first one is streaming out.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      bus.valid_i   = 1'b1;
      bus.data_in_r = fr_r[1][i];
      bus.data_in_i = fr_i[1][i];
    end
    @(negedge clk);
    bus.valid_i = 1'b0;
    checks++;
    if (bus.valid_o !== 1'b1)
      begin errors++; $display("FAIL midrst_pre: valid_o=%b, required 1", bus.valid_o); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.valid_o !== 1'b0 || bus.sop_o !== 1'b0 || bus.data_out_r !== '0 || bus.data_out_i !== '0)
      begin errors++; $display("FAIL midrst_async: valid=%b sop=%b r=%0d i=%0d, required all 0",
                               bus.valid_o, bus.sop_o, bus.data_out_r, bus.data_out_i); end
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    fill_random(0);
    drive_frames(1, 1'b0, last);
    wait_outputs(32, 80, ok);
    repeat (40) @(negedge clk);
    #1;
    checks++;
    if (mon_r.size() != 32) begin
      errors++; $display("FAIL midrst_count: got %0d outputs, required 32", mon_r.size());
    end else begin
      for (int j = 0; j < 32; j++) begin
        checks++;
        if (mon_r[j] !== exp_r(0, j) || mon_i[j] !== exp_i(0, j) ||
            mon_sop[j] !== (j == 0) || mon_cyc[j] != last + 2 + j) begin
          errors++;
          $display("FAIL midrst X[%0d]: r=%0d i=%0d sop=%b cyc=%0d, required r=%0d i=%0d sop=%b cyc=%0d",
                   j, mon_r[j], mon_i[j], mon_sop[j], mon_cyc[j], exp_r(0, j), exp_i(0, j), j == 0, last + 2 + j);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_frame();
    test_back_to_back();
    test_gapped();
    test_extremes();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fft_reorder32.md
# fft_reorder32

Output reorder buffer for the 32-point SDF FFT pipeline. It consumes the final stage's complex stream, which arrives in bit-reversed index order, and re-emits each 32-sample frame in natural order (X[0]..X[31]). It sits after the last butterfly stage and is the reader-side counterpart of the pipeline's bit-reversed writer. It uses a ping-pong buffer of two 32-word banks so that back-to-back frames stream out with no bubbles.

## Interface
- DATA_W, 19: width of each real and imaginary component (signed, two's complement).
- LOG2N, 5: log2 of frame length; N = 2**LOG2N = 32.

- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- valid_i  input  1  input sample strobe; one sample is accepted per cycle in which it is high.
- data_in_r  input  DATA_W  real part, signed.
- data_in_i  input  DATA_W  imaginary part, signed.
- valid_o  output  1  output sample valid (registered).
- sop_o  output  1  high with the first output sample (X[0]) of each frame (registered).
- data_out_r  output  DATA_W  real part in natural order (registered).
- data_out_i  output  DATA_W  imaginary part in natural order (registered).

## Operation
- Storage: 2 banks × N words × 2·DATA_W bits. Memory is not reset.
- Frame alignment: the first valid_i after reset is input index 0 of a frame. Input index i carries X[bitrev(i)], where bitrev reverses LOG2N bits.
- Writer:
  - wr_cnt (LOG2N bits) and wr_bank (1 bit).
  - On valid_i, write mem[wr_bank][bitrev(wr_cnt)], then increment wr_cnt.
  - When wr_cnt wraps from N-1 to 0: set full[wr_bank] and toggle wr_bank.
  - Gaps in valid_i are allowed; wr_cnt holds during gaps.
- Reader FSM, states IDLE and READ:
  - IDLE: if full[rd_bank], go to READ with rd_cnt=0.
  - READ: each cycle, register mem[rd_bank][rd_cnt] to the outputs, assert valid_o, and assert sop_o when rd_cnt==0.
  - At rd_cnt==N-1: clear full[rd_bank] and toggle rd_bank. If full[other bank] is set, stay in READ with rd_cnt=0 (no bubble); otherwise go to IDLE.
- Simultaneous events:
  - Setting full on one bank and clearing it on the other in the same cycle are both honoured.
  - The reader drains N samples in exactly N cycles, and the writer needs at least N cycles to fill a bank. The writer therefore never targets a full bank; no overflow logic is required.
- Outputs outside READ: valid_o=0, sop_o=0, data_out_r=0, data_out_i=0.
- Arithmetic: none. Data passes through bit-exact.

## Timing
- Reset values: valid_o=0, sop_o=0, data_out_r=0, data_out_i=0, wr_cnt=0, wr_bank=0, rd_bank=0, rd_cnt=0, full=2'b00, FSM=IDLE.
- Latency: if the last (N-th) input sample of a frame is accepted in cycle k, X[0] appears in cycle k+2, and X[31] appears in cycle k+33.
- Back-to-back input (valid_i held high continuously): the output is continuous. valid_o stays high from the first frame onward, and sop_o pulses every 32 cycles.
- Rate: at most one output per cycle; there is no backpressure.
- Reset mid-operation:
  - All counters and flags clear and any partial frame is discarded.
  - Outputs go to 0 asynchronously.
  - The next valid_i after reset deassertion is index 0 of a new frame.

## Test plan
- Single frame: 32 consecutive valid_i with data_in_r=i, data_in_i=-i. Required: valid_o high for 32 cycles starting at k+2, data_out_r = 0,16,8,24,4,20,12,28,2,..., 31, data_out_i = the negation, and sop_o only on the first output.
- Back-to-back: 4 frames with valid_i continuously high. Required: valid_o high continuously for 128 cycles, sop_o at output cycles 0, 32, 64 and 96, and each frame correctly reordered.
- Gapped input: valid_i toggling 1,0,1,0 across one frame. Required: output begins 2 cycles after the 32nd accepted sample, is contiguous for 32 cycles, and has the same order as the single-frame case.
- Reset mid-frame: assert rst after 17 samples, then send a full frame. Required: no output from the partial frame, and the new frame is output correctly.
- Extremes: values -2^18 and 2^18-1 at indices 0 and 31. Required: bit-exact values at outputs X[0] and X[31].
- Idle: no valid_i for 100 cycles after reset. Required: valid_o=0, sop_o=0 and data outputs 0 throughout.
